// File: rtl/obi_req_fifo.sv
// Circular request buffer between the core OBI request port and the bus.
// Head fields are driven from storage only; a full buffer still accepts when the head pops.
module obi_req_fifo #(
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int BE_WIDTH  = DATA_WIDTH / 8,
    localparam int LVL_WIDTH = $clog2(DEPTH + 1),
    localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  core_req_i,
    input  logic [ADDR_WIDTH-1:0] core_addr_i,
    input  logic                  core_we_i,
    input  logic [BE_WIDTH-1:0]   core_be_i,
    input  logic [DATA_WIDTH-1:0] core_wdata_i,
    output logic                  core_gnt_o,
    output logic                  bus_req_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic                  bus_we_o,
    output logic [BE_WIDTH-1:0]   bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    output logic [LVL_WIDTH-1:0]  level_o,
    output logic                  flush_drop_o
);

    logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
    logic                  we_mem    [DEPTH];
    logic [BE_WIDTH-1:0]   be_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] wdata_mem [DEPTH];

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [LVL_WIDTH-1:0] count;
    logic                 push;
    logic                 pop;
    logic                 not_full;
    logic                 not_empty;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        if (p == PTR_WIDTH'(DEPTH - 1))
            return '0;
        else
            return p + PTR_WIDTH'(1);
    endfunction

    assign not_full  = (count != LVL_WIDTH'(DEPTH));
    assign not_empty = (count != '0);

    assign bus_req_o   = not_empty & ~flush_i;
    assign pop         = bus_req_o & bus_gnt_i;
    // rst_i gates the grant so every output reads 0 while reset is held
    assign core_gnt_o  = core_req_i & ~flush_i & ~rst_i & (not_full | pop);
    assign push        = core_req_i & core_gnt_o;

    assign bus_addr_o  = addr_mem[rd_ptr];
    assign bus_we_o    = bus_req_o & we_mem[rd_ptr];
    assign bus_be_o    = be_mem[rd_ptr];
    assign bus_wdata_o = wdata_mem[rd_ptr];
    assign level_o     = count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i]  <= '0;
                we_mem[i]    <= 1'b0;
                be_mem[i]    <= '0;
                wdata_mem[i] <= '0;
            end
        end else if (push) begin
            addr_mem[wr_ptr]  <= core_addr_i;
            we_mem[wr_ptr]    <= core_we_i;
            be_mem[wr_ptr]    <= core_be_i;
            wdata_mem[wr_ptr] <= core_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            flush_drop_o <= 1'b0;
        end else begin
            flush_drop_o <= flush_i & not_empty;
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= ptr_inc(wr_ptr);
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   count <= count + LVL_WIDTH'(1);
                    2'b01:   count <= count - LVL_WIDTH'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule
